// File: rtl/pwf_1557.sv
// Pulse-width filter: passes the gate only after MIN_HIGH consecutive high samples,
// drops it on the first low sample. Shorter pulses never reach the output.
module pwf_1557 #(
  parameter int unsigned MIN_HIGH = 12,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk11m,
  input  logic rst_n,
  input  logic g,
  output logic i
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_i;
  logic             w_i_nxt;

  // State, run-length counter and output flop
  always_ff @(posedge clk11m) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_i     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_i     <= w_i_nxt;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_i_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (g) begin
          w_cnt_nxt   = LP_ONE;
          w_state_nxt = COUNT;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      COUNT: begin
        if (!g) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt == LP_LAST) begin
          // This edge takes the MIN_HIGH-th sample; counter holds
          w_state_nxt = ACTIVE;
          w_i_nxt     = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + LP_ONE;
        end
      end
      ACTIVE: begin
        if (g) begin
          w_i_nxt     = 1'b1;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign i = r_i;

endmodule

// File: tb/tb_pwf_1557.sv
// Directed bench for pwf_1557 at default parameters (MIN_HIGH=12).
module tb_pwf_1557;

  logic clk11m = 1'b0;
  logic rst_n;
  logic g;
  logic i;

  int n_checks = 0;
  int n_fail   = 0;

  pwf_1557 #(.MIN_HIGH(12), .CNT_W(8)) dut (
    .clk11m (clk11m),
    .rst_n  (rst_n),
    .g      (g),
    .i      (i)
  );

  always #5 clk11m = ~clk11m;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive g, take one edge, sample i 1ns later
  task automatic step(input logic gv, input int exp_i, input string tag, output int obs);
    g = gv;
    @(posedge clk11m);
    #1;
    obs = int'(i);
    check(tag, obs, exp_i);
  endtask

  // n high samples then one low sample; i must be high from the 12th high on
  task automatic pulse(input int n, input int exp_hi, input string tag);
    int obs;
    int hi;
    hi = 0;
    for (int j = 1; j <= n; j++) begin
      step(1'b1, (j >= 12) ? 1 : 0, $sformatf("%s_h%0d", tag, j), obs);
      hi += obs;
    end
    step(1'b0, 0, $sformatf("%s_low", tag), obs);
    check($sformatf("%s_hicnt", tag), hi, exp_hi);
  endtask

  initial begin
    int obs;
    rst_n = 1'b0;
    g     = 1'b0;

    // Reset held with g toggling
    for (int k = 0; k < 4; k++) begin
      step(k[0] ? 1'b0 : 1'b1, 0, $sformatf("rst_i%0d", k), obs);
      check($sformatf("rst_cnt%0d", k), int'(dut.r_cnt), 0);
    end

    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b0, 0, $sformatf("rel_i%0d", k), obs);

    pulse(14, 3, "long14");
    pulse(10, 0, "short10");
    pulse(11, 0, "edge11");
    pulse(12, 1, "edge12");
    step(1'b0, 0, "gap", obs);

    // Back-to-back: 5 high, 1 low, 12 high with no extra gap
    pulse(5, 0, "b2b_a");
    pulse(12, 1, "b2b_b");

    // Reset while ACTIVE with g held high
    for (int j = 1; j <= 13; j++) step(1'b1, (j >= 12) ? 1 : 0, $sformatf("act_h%0d", j), obs);
    rst_n = 1'b0;
    step(1'b1, 0, "midrst_0", obs);
    step(1'b1, 0, "midrst_1", obs);
    check("midrst_cnt", int'(dut.r_cnt), 0);
    rst_n = 1'b1;
    for (int j = 1; j <= 14; j++) step(1'b1, (j >= 12) ? 1 : 0, $sformatf("post_h%0d", j), obs);
    step(1'b0, 0, "post_low", obs);
    step(1'b0, 0, "post_idle", obs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwf_1557.md
# pwf_1557

Pulse-width filter (glitch/short-pulse discriminator) for a single-bit gate signal `g`. The output `i` asserts only after `g` has been sampled high for `MIN_HIGH` consecutive clocks, then follows `g` low with one-clock latency. Shorter high pulses are rejected entirely. The block sits between a raw gate/enable input and downstream logic that must ignore short spurious pulses.

## Interface
- `MIN_HIGH`, default 12: number of consecutive high samples of `g` required before `i` asserts. Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 8: width of the run-length counter.
- `clk11m`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low, sampled on the rising edge of `clk11m`.
- `g`  input  1  gate input. It must be synchronous to `clk11m`; the block does not synchronise it.
- `i`  output  1  filtered gate, registered.

## Operation
- **State register:** one of three states.
  - `IDLE`: waiting for `g` to go high.
  - `COUNT`: `g` is high but the required run length is not yet reached.
  - `ACTIVE`: the pulse is qualified.
- **Counter:** `cnt` is `CNT_W` bits wide and holds the number of consecutive high samples taken so far.
- **Reset** (`rst_n`=0 at a rising edge): state goes to `IDLE`, `cnt`=0, `i`=0. Reset overrides every other condition, including mid-count and mid-`ACTIVE`.
- **IDLE:**
  - `g`=1 → `cnt`←1, go to `COUNT`.
  - `g`=0 → stay in `IDLE`, `cnt`=0, `i`=0.
- **COUNT:**
  - `g`=0 → `cnt`←0, go to `IDLE`. The pulse is rejected and `i` stays 0.
  - `g`=1 and `cnt`==`MIN_HIGH`-1 → go to `ACTIVE`, `i`←1. `cnt` holds its value (no wrap).
  - `g`=1 otherwise → `cnt`←`cnt`+1.
- **ACTIVE:**
  - `g`=1 → stay in `ACTIVE`, `i`=1, `cnt` held.
  - `g`=0 → `i`←0, `cnt`←0, go to `IDLE`.
- **Unused state encodings:** must recover to `IDLE` with `i`=0 on the next edge.
- **No re-trigger gap:** a new pulse can start counting on the edge immediately after a rejection or a release. This is because `IDLE` with `g`=1 counts that sample.
- **Width rule:** `cnt` never exceeds `MIN_HIGH`-1, so it cannot overflow for legal parameter values.

## Timing
- `i` is a flop output with no combinational path from `g`.
- **Assertion latency:** if `g` is sampled high at rising edges k … k+`MIN_HIGH`-1, then `i` goes to 1 at edge k+`MIN_HIGH`-1. That is the same edge that takes the `MIN_HIGH`-th high sample.
- **Deassertion latency:** `i` goes to 0 at the first edge that samples `g`=0.
- **High time of `i`:** for a pulse of N ≥ `MIN_HIGH` high samples, `i` is high for exactly N-`MIN_HIGH`+1 clocks.
- **Rejected pulses:** a pulse of N < `MIN_HIGH` samples produces `i`=0 throughout.
- **Boundary case N = `MIN_HIGH`-1:** rejected.
- **Boundary case N = `MIN_HIGH`:** exactly one clock of `i`=1.
- **Reset release:** the first edge with `rst_n`=1 and `g`=1 counts as sample 1.
- **Reset while `ACTIVE`:** `i` is 0 at that edge. Counting restarts from 1 on the first post-reset edge that sees `g`=1.

## Test plan
- **Reset:** hold `rst_n`=0 for ≥2 clocks with `g` toggling → `i`=0 throughout and `cnt`=0. Then release with `g`=0 → `i` stays 0.
- **Long pulse (default `MIN_HIGH`=12):** `g` high for 14 samples → `i` rises at the 12th high edge, stays high 3 clocks, and falls at the first edge sampling `g`=0.
- **Short pulse (default `MIN_HIGH`=12):** `g` high for 10 samples → `i`=0 for the whole pulse and after it.
- **Boundary pulses:** `g` high for 11 samples → `i` never asserts. `g` high for 12 samples → `i` high for exactly 1 clock.
- **Back-to-back pulses:** 5 high, 1 low, 12 high → the first pulse is rejected; the second asserts `i` at its 12th high edge, counted from 1 on the edge after the low sample.
- **Reset mid-operation:** assert `rst_n`=0 during `ACTIVE` with `g`=1 held → `i`=0 at the reset edge. After release with `g` still 1, `i` re-asserts 12 edges after the release edge (that edge counted as sample 1).
